// File: rtl/mem_burst_master_if.sv
// Client-side command/write/read streams and the memory port of mem_burst_master.
// The master modport is the initiator's view; slave is the client/memory side.
interface mem_burst_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data, rd_last,
    input  rd_ready,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data, rd_last,
    output rd_ready,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port sync memory with a 1-cycle registered read.
// Writes stream straight to the port; reads return through a credit-guarded 4-entry FIFO.
module mem_burst_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               reset,
  mem_burst_master_if.master bus,
  output logic               busy
);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ_ISSUE, READ_DRAIN} state_t;
  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [LEN_WIDTH-1:0]  pop_cnt;
  logic                  issue_q;
  logic                  return_q;
  logic [DATA_WIDTH-1:0] fifo_mem [4];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            fifo_count;
  logic [2:0]            credit_used;

  logic cmd_ready, wr_ready, issue;
  logic credit_ok, cmd_fire, wr_fire, pop;
  logic fifo_nonempty, last_beat, rd_last;

  // issue_q: address on the port this cycle; return_q: its data on mem_rdata now.
  assign credit_used   = fifo_count + {2'b00, issue_q} + {2'b00, return_q};
  assign credit_ok     = credit_used <= 3'd3;
  assign fifo_nonempty = fifo_count != 3'd0;
  assign pop           = fifo_nonempty && bus.rd_ready;
  assign last_beat     = beat_cnt == len_q;
  assign cmd_fire      = cmd_ready && bus.cmd_valid;
  assign wr_fire       = wr_ready && bus.wr_valid;
  assign rd_last       = fifo_nonempty && (pop_cnt == len_q);

  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = fifo_nonempty;
  assign bus.rd_data   = fifo_mem[rd_ptr];
  assign bus.rd_last   = rd_last;
  assign busy          = state != IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !reset;
        if (!reset && bus.cmd_valid)
          state_next = bus.cmd_write ? WRITE : READ_ISSUE;
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (bus.wr_valid && last_beat) state_next = IDLE;
      end
      READ_ISSUE: begin
        issue = credit_ok;
        if (credit_ok && last_beat) state_next = READ_DRAIN;
      end
      READ_DRAIN: begin
        if (pop && rd_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory port, burst counters and the read-return pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cur_addr      <= '0;
      len_q         <= '0;
      beat_cnt      <= '0;
      pop_cnt       <= '0;
      issue_q       <= 1'b0;
      return_q      <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (cmd_fire) begin
        cur_addr <= bus.cmd_addr;
        len_q    <= bus.cmd_len;
        beat_cnt <= '0;
        pop_cnt  <= '0;
      end
      if (wr_fire) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= cur_addr;
        bus.mem_wdata <= bus.wr_data;
        cur_addr      <= cur_addr + ADDR_ONE;
        beat_cnt      <= beat_cnt + LEN_ONE;
      end
      if (issue) begin
        bus.mem_addr <= cur_addr;
        cur_addr     <= cur_addr + ADDR_ONE;
        beat_cnt     <= beat_cnt + LEN_ONE;
      end
      issue_q  <= issue;
      return_q <= issue_q;
      if (return_q) begin
        fifo_mem[wr_ptr] <= bus.mem_rdata;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 2'd1;
        pop_cnt <= pop_cnt + LEN_ONE;
      end
      fifo_count <= fifo_count + {2'b00, return_q} - {2'b00, pop};
    end
  end
endmodule
